decode_stage: RTL and testbench

- Registered, handshaked instruction-decode pipeline stage. It sits between the fetch stage and the register-file/ALU stage.
- Extends the combinational R/I-type decoder with three additions: LUI, LOAD and STORE formats; correct SRAI/SRLI alu_op; explicit control strobes.
- Carries an illegal-instruction flag and a PC passthrough.
- Decoded fields are held in a one-entry output register with a valid/ready handshake and a flush input.

---
 rtl/decode_stage_if.sv | 46 ++++
 rtl/decode_stage.sv | 190 +++++++++++++++++++
 tb/tb_decode_stage.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage_if
// Brief    : Fetch-side and execute-side handshake bundle of the decode stage.
// Revision : 1.0
// ============================================================================
interface decode_stage_if #(
    parameter int WORD_SIZE = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          instruction;
    logic [WORD_SIZE-1:0] in_pc;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [WORD_SIZE-1:0] out_pc;
    logic [6:0]           opcode;
    logic [4:0]           rd;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic                 rs2_use_imm;
    logic [3:0]           alu_op;
    logic [WORD_SIZE-1:0] immediate;
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
    logic                 illegal;

    // Environment side: feeds instructions and consumes decoded bundles.
    modport master (
        output in_valid, instruction, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, opcode, rd, rs1, rs2,
               rs2_use_imm, alu_op, immediate, reg_write, mem_read,
               mem_write, illegal
    );

    // Decode stage side.
    modport slave (
        input  in_valid, instruction, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, opcode, rd, rs1, rs2,
               rs2_use_imm, alu_op, immediate, reg_write, mem_read,
               mem_write, illegal
    );
endinterface
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Brief    : Registered RV32 R/I/LUI/LOAD/STORE decoder with valid/ready/flush.
// Revision : 1.0
// ============================================================================
module decode_stage #(
    parameter int WORD_SIZE           = 32,
    parameter int ILLEGAL_WRITES_ZERO = 1
) (
    input  wire            clk,
    input  wire            reset,
    decode_stage_if.slave  bus
);
    localparam logic [6:0] c_OP_R     = 7'b0110011;
    localparam logic [6:0] c_OP_I_ALU = 7'b0010011;
    localparam logic [6:0] c_OP_LUI   = 7'b0110111;
    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;

    logic [31:0]          w_instr;
    logic [2:0]           w_funct3;
    logic [6:0]           w_funct7;
    logic [4:0]           w_rd;
    logic [4:0]           w_rs1;
    logic [4:0]           w_rs2;
    logic                 w_use_imm;
    logic [3:0]           w_alu_op;
    logic [WORD_SIZE-1:0] w_imm;
    logic                 w_reg_write;
    logic                 w_mem_read;
    logic                 w_mem_write;
    logic                 w_illegal;
    logic                 w_capture;

    logic                 r_valid;
    logic [WORD_SIZE-1:0] r_pc;
    logic [6:0]           r_opcode;
    logic [4:0]           r_rd;
    logic [4:0]           r_rs1;
    logic [4:0]           r_rs2;
    logic                 r_use_imm;
    logic [3:0]           r_alu_op;
    logic [WORD_SIZE-1:0] r_imm;
    logic                 r_reg_write;
    logic                 r_mem_read;
    logic                 r_mem_write;
    logic                 r_illegal;

    assign w_instr  = bus.instruction;
    assign w_funct3 = w_instr[14:12];
    assign w_funct7 = w_instr[31:25];

    // Replication counts use WORD_SIZE-31 / -11 / -5 so they stay >= 1 at 32 bits.
    always_comb begin
        w_rd        = 5'd0;
        w_rs1       = 5'd0;
        w_rs2       = 5'd0;
        w_use_imm   = 1'b0;
        w_alu_op    = 4'd0;
        w_imm       = '0;
        w_reg_write = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_illegal   = 1'b0;
        case (w_instr[6:0])
            c_OP_R: begin
                w_rd        = w_instr[11:7];
                w_rs1       = w_instr[19:15];
                w_rs2       = w_instr[24:20];
                w_alu_op    = {w_instr[30], w_funct3};
                w_reg_write = 1'b1;
            end
            c_OP_I_ALU: begin
                w_rd        = w_instr[11:7];
                w_rs1       = w_instr[19:15];
                w_use_imm   = 1'b1;
                w_reg_write = 1'b1;
                if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
                    w_alu_op = {w_instr[30], w_funct3};
                    w_imm    = {{(WORD_SIZE-5){1'b0}}, w_instr[24:20]};
                    if (w_funct3 == 3'b001 && w_funct7 != 7'b0000000)
                        w_illegal = 1'b1;
                    if (w_funct3 == 3'b101 && w_funct7 != 7'b0000000 && w_funct7 != 7'b0100000)
                        w_illegal = 1'b1;
                end else begin
                    w_alu_op = {1'b0, w_funct3};
                    w_imm    = {{(WORD_SIZE-11){w_instr[31]}}, w_instr[30:20]};
                end
            end
            c_OP_LUI: begin
                w_rd        = w_instr[11:7];
                w_use_imm   = 1'b1;
                w_imm       = {{(WORD_SIZE-31){w_instr[31]}}, w_instr[30:12], 12'b0};
                w_reg_write = 1'b1;
            end
            c_OP_LOAD: begin
                w_rd        = w_instr[11:7];
                w_rs1       = w_instr[19:15];
                w_use_imm   = 1'b1;
                w_imm       = {{(WORD_SIZE-11){w_instr[31]}}, w_instr[30:20]};
                w_mem_read  = 1'b1;
                w_reg_write = 1'b1;
            end
            c_OP_STORE: begin
                w_rs1       = w_instr[19:15];
                w_rs2       = w_instr[24:20];
                w_use_imm   = 1'b1;
                w_imm       = {{(WORD_SIZE-11){w_instr[31]}}, w_instr[30:25], w_instr[11:7]};
                w_mem_write = 1'b1;
            end
            default: begin
                w_illegal = 1'b1;
                w_rd      = w_instr[11:7];
                w_rs1     = w_instr[19:15];
                w_rs2     = w_instr[24:20];
            end
        endcase
        // Illegal instructions never produce side effects downstream.
        if (w_illegal) begin
            w_reg_write = 1'b0;
            w_mem_read  = 1'b0;
            w_mem_write = 1'b0;
            if (ILLEGAL_WRITES_ZERO != 0) begin
                w_rd      = 5'd0;
                w_rs1     = 5'd0;
                w_rs2     = 5'd0;
                w_use_imm = 1'b0;
                w_alu_op  = 4'd0;
                w_imm     = '0;
            end
        end
        if (w_rd == 5'd0)
            w_reg_write = 1'b0;
    end

    assign bus.in_ready = !bus.flush && (!r_valid || bus.out_ready);
    assign w_capture    = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_opcode    <= 7'd0;
            r_rd        <= 5'd0;
            r_rs1       <= 5'd0;
            r_rs2       <= 5'd0;
            r_use_imm   <= 1'b0;
            r_alu_op    <= 4'd0;
            r_imm       <= '0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid     <= 1'b1;
            r_pc        <= bus.in_pc;
            r_opcode    <= w_instr[6:0];
            r_rd        <= w_rd;
            r_rs1       <= w_rs1;
            r_rs2       <= w_rs2;
            r_use_imm   <= w_use_imm;
            r_alu_op    <= w_alu_op;
            r_imm       <= w_imm;
            r_reg_write <= w_reg_write;
            r_mem_read  <= w_mem_read;
            r_mem_write <= w_mem_write;
            r_illegal   <= w_illegal;
        end else if (r_valid && bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.out_valid   = r_valid;
    assign bus.out_pc      = r_pc;
    assign bus.opcode      = r_opcode;
    assign bus.rd          = r_rd;
    assign bus.rs1         = r_rs1;
    assign bus.rs2         = r_rs2;
    assign bus.rs2_use_imm = r_use_imm;
    assign bus.alu_op      = r_alu_op;
    assign bus.immediate   = r_imm;
    assign bus.reg_write   = r_reg_write;
    assign bus.mem_read    = r_mem_read;
    assign bus.mem_write   = r_mem_write;
    assign bus.illegal     = r_illegal;
endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Brief    : Directed self-checking bench for decode_stage with a format-level model.
// Revision : 1.0
// ============================================================================
module tb_decode_stage;
    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        use_imm;
        logic [3:0]  alu_op;
        logic [31:0] imm;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        illegal;
    } dec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;

    decode_stage_if #(.WORD_SIZE(32)) bus ();

    decode_stage #(.WORD_SIZE(32), .ILLEGAL_WRITES_ZERO(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference decode by instruction format.
    function automatic dec_t model_decode(input logic [31:0] i);
        dec_t d;
        d = '0;
        d.opcode = i[6:0];
        unique case (i[6:0])
            7'h33: begin
                d.rd = i[11:7]; d.rs1 = i[19:15]; d.rs2 = i[24:20];
                d.alu_op = {i[30], i[14:12]}; d.reg_write = 1'b1;
            end
            7'h13: begin
                d.rd = i[11:7]; d.rs1 = i[19:15]; d.use_imm = 1'b1; d.reg_write = 1'b1;
                if (i[14:12] == 3'd1 || i[14:12] == 3'd5) begin
                    d.alu_op = {i[30], i[14:12]};
                    d.imm    = 32'(i[24:20]);
                    d.illegal = (i[14:12] == 3'd1) ? (i[31:25] != 7'h00)
                                                   : !(i[31:25] inside {7'h00, 7'h20});
                end else begin
                    d.alu_op = {1'b0, i[14:12]};
                    d.imm    = 32'($signed(i[31:20]));
                end
            end
            7'h37: begin
                d.rd = i[11:7]; d.use_imm = 1'b1; d.imm = {i[31:12], 12'h000}; d.reg_write = 1'b1;
            end
            7'h03: begin
                d.rd = i[11:7]; d.rs1 = i[19:15]; d.use_imm = 1'b1;
                d.imm = 32'($signed(i[31:20])); d.mem_read = 1'b1; d.reg_write = 1'b1;
            end
            7'h23: begin
                d.rs1 = i[19:15]; d.rs2 = i[24:20]; d.use_imm = 1'b1;
                d.imm = 32'($signed({i[31:25], i[11:7]})); d.mem_write = 1'b1;
            end
            default: d.illegal = 1'b1;
        endcase
        if (d.illegal) begin
            d = '0;
            d.opcode  = i[6:0];
            d.illegal = 1'b1;
        end
        if (d.rd == 5'd0) d.reg_write = 1'b0;
        return d;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    endtask

    // One-entry output register model.
    logic        m_valid;
    dec_t        m_dec;
    logic [31:0] m_pc;
    logic        m_in_ready;
    assign m_in_ready = !bus.flush && (!m_valid || bus.out_ready);

    always @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_dec   <= '0;
            m_pc    <= '0;
        end else if (bus.flush) begin
            m_valid <= 1'b0;
        end else if (bus.in_valid && m_in_ready) begin
            m_valid <= 1'b1;
            m_dec   <= model_decode(bus.instruction);
            m_pc    <= bus.in_pc;
        end else if (m_valid && bus.out_ready) begin
            m_valid <= 1'b0;
        end
    end

    dec_t got_dec;
    assign got_dec = '{bus.opcode, bus.rd, bus.rs1, bus.rs2, bus.rs2_use_imm, bus.alu_op,
                       bus.immediate, bus.reg_write, bus.mem_read, bus.mem_write, bus.illegal};

    logic model_live = 1'b0;
    always @(negedge clk) begin
        if (model_live) begin
            chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
            chk("in_ready", 32'(bus.in_ready), 32'(m_in_ready));
            if (m_valid) begin
                n_checks++;
                if (got_dec === m_dec && bus.out_pc === m_pc) n_pass++;
                else $display("FAIL bundle: got %h pc %h expected %h pc %h",
                              got_dec, bus.out_pc, m_dec, m_pc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] ins, input logic [31:0] pc);
        bus.in_valid    = 1'b1;
        bus.instruction = ins;
        bus.in_pc       = pc;
    endtask

    dec_t snap;

    initial begin
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.instruction = '0; bus.in_pc = '0;
        bus.flush = 1'b0; bus.out_ready = 1'b1;
        step(); step();
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset fields", 32'(got_dec != '0), 32'd0);
        reset = 1'b0;
        model_live = 1'b1;

        offer(32'h002081B3, 32'h100); step();
        chk("add rd", 32'(bus.rd), 32'd3);
        chk("add rs1/rs2", {bus.rs1, bus.rs2}, {5'd1, 5'd2});
        chk("add alu/rw/ill", {bus.alu_op, bus.reg_write, bus.illegal}, {4'h0, 1'b1, 1'b0});
        offer(32'h407302B3, 32'h104); step();
        chk("sub alu/rd", {bus.alu_op, bus.rd}, {4'h8, 5'd5});
        offer(32'hFFF00093, 32'h108); step();
        chk("addi imm", bus.immediate, 32'hFFFF_FFFF);
        chk("addi use_imm/rd", {bus.rs2_use_imm, bus.rd}, {1'b1, 5'd1});
        offer(32'h40315113, 32'h10C); step();
        chk("srai alu/imm", {bus.alu_op, bus.immediate[27:0]}, {4'hD, 28'd3});
        offer(32'h123452B7, 32'h110); step();
        chk("lui imm", bus.immediate, 32'h1234_5000);
        chk("lui rs1", 32'(bus.rs1), 32'd0);
        offer(32'h00112423, 32'h114); step();
        chk("sw strobes", {bus.mem_write, bus.reg_write, bus.mem_read}, {1'b1, 1'b0, 1'b0});
        chk("sw fields", {bus.rs1, bus.rs2, bus.immediate[21:0]}, {5'd2, 5'd1, 22'd8});
        offer(32'hFFC1A203, 32'h118); step();
        chk("lw imm/mr", {bus.immediate[30:0], bus.mem_read}, {31'h7FFF_FFFC, 1'b1});
        offer(32'h0030D113, 32'h11C); step();
        chk("srli alu", 32'(bus.alu_op), 32'h5);
        offer(32'h40109093, 32'h120); step();
        chk("slli bad funct7", {bus.illegal, bus.reg_write}, {1'b1, 1'b0});
        offer(32'h00000013, 32'h124); step();
        chk("addi x0 rw", 32'(bus.reg_write), 32'd0);

        // Backpressure with a new instruction waiting.
        bus.out_ready = 1'b0;
        offer(32'h002081B3, 32'h128);
        snap = got_dec;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall in_ready", 32'(bus.in_ready), 32'd0);
            step();
            chk("stall stable", 32'(got_dec == snap && bus.out_pc == 32'h124), 32'd1);
        end
        bus.out_ready = 1'b1;
        step();
        chk("post-stall rd/pc", {bus.rd, bus.out_pc[26:0]}, {5'd3, 27'h128});

        offer(32'h00000000, 32'h12C); step();
        chk("illegal flags", {bus.illegal, bus.reg_write, bus.mem_read, bus.mem_write},
            {1'b1, 1'b0, 1'b0, 1'b0});
        chk("illegal zero fields", {bus.opcode, bus.rd, bus.immediate[19:0]}, 32'd0);

        // Flush during a stall with an instruction offered.
        bus.out_ready = 1'b0;
        offer(32'h407302B3, 32'h130); step();
        bus.flush = 1'b1; step();
        chk("flush valid", 32'(bus.out_valid), 32'd0);
        bus.flush = 1'b0; bus.in_valid = 1'b0; step();
        chk("flush no capture", 32'(bus.out_valid), 32'd0);

        // Reset during a stall.
        bus.out_ready = 1'b1;
        offer(32'h002081B3, 32'h134); step();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; step();
        chk("held before reset", 32'(bus.out_valid), 32'd1);
        reset = 1'b1; step();
        chk("reset mid-stall", 32'(bus.out_valid), 32'd0);
        reset = 1'b0; bus.out_ready = 1'b1; step(); step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
